// File: rtl/mul32_seq_ctrl.sv
// Sequential unsigned 32x32 -> 64 shift-add multiplier built around one
// reused 32-bit carry-lookahead adder. Start/done handshake with busy flag.

// 4-bit carry-lookahead slice: sum bits plus group generate/propagate.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       gg,
   output logic       gp
);
   logic [3:0] g, p;
   logic [3:0] c;

   // bit generate/propagate and flattened lookahead carries
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      s    = p ^ c;
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      gp   = &p;
   end
endmodule

// 32-bit adder: eight cla4 slices joined by group generate/propagate.
module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] s,
   output logic        co
);
   localparam int NUM_GRP = 8;
   logic [NUM_GRP-1:0][3:0] a_g, b_g, s_g;
   logic [NUM_GRP-1:0]      gg, gp;
   logic [NUM_GRP:0]        gc;

   assign a_g = a;
   assign b_g = b;
   assign s   = s_g;
   assign co  = gc[NUM_GRP];
   assign gc[0] = ci;

   genvar i;
   generate
      for (i = 0; i < NUM_GRP; i++) begin : g_grp
         cla4 u_cla4 (
            .a  (a_g[i]),
            .b  (b_g[i]),
            .ci (gc[i]),
            .s  (s_g[i]),
            .gg (gg[i]),
            .gp (gp[i])
         );
         assign gc[i+1] = gg[i] | (gp[i] & gc[i]);
      end
   endgenerate
endmodule

module mul32_seq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] result
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] mcand, hi, lo;
   logic [4:0]  cnt;
   logic        accept;
   logic        last;
   logic [31:0] addend, sum;
   logic        co;
   logic [63:0] prod_nxt;

   // one partial-product add per EXEC cycle; carry lands in bit 63 after shift
   assign addend   = lo[0] ? mcand : 32'h0;
   assign prod_nxt = {co, sum, lo[31:1]};
   assign last     = (cnt == 5'd31);

   cla32 u_cla32 (
      .a  (hi),
      .b  (addend),
      .ci (1'b0),
      .s  (sum),
      .co (co)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and handshake outputs; DONE accepts start like IDLE
   always_comb begin
      state_nxt = IDLE;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            accept    = start;
            state_nxt = start ? EXEC : IDLE;
         end
         EXEC: begin
            busy      = 1'b1;
            state_nxt = last ? DONE : EXEC;
         end
         DONE: begin
            done      = 1'b1;
            accept    = start;
            state_nxt = start ? EXEC : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // datapath: load on accept, shift-add in EXEC, publish only on the last step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= 32'h0;
         hi     <= 32'h0;
         lo     <= 32'h0;
         cnt    <= 5'd0;
         result <= 64'h0;
      end else if (accept) begin
         mcand <= a;
         hi    <= 32'h0;
         lo    <= b;
         cnt   <= 5'd0;
      end else if (state == EXEC) begin
         {hi, lo} <= prod_nxt;
         cnt      <= cnt + 5'd1;
         if (last) result <= prod_nxt;
      end
   end
endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl: latency, products, handshake corners.
module tb_mul32_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic        busy, done;
   logic [63:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mul32_seq_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // present start for one edge; returns at the negedge following the accept edge
   task automatic launch(input logic [31:0] ea, input logic [31:0] eb);
      @(negedge clk);
      start = 1'b1;
      a     = ea;
      b     = eb;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // k counts edges after the accept edge; done must show after edge 32,
   // busy for the 32 cycles before it, and result must hold its old value
   task automatic wait_done(input string tag, input logic [63:0] exp,
                            input logic [63:0] hold, input bit inj);
      int k = 0;
      int nb = 0;
      int held_bad = 0;
      while (!done && k < 40) begin
         if (busy) nb++;
         if (result !== hold) held_bad++;
         if (inj && k == 10) begin start = 1'b1; a = 32'd100; b = 32'd100; end
         if (inj && k == 11) start = 1'b0;
         @(negedge clk);
         k++;
      end
      chk({tag, " done edge"}, 64'(k), 64'd32);
      chk({tag, " busy cycles"}, 64'(nb), 64'd32);
      chk({tag, " result held"}, 64'(held_bad), 64'd0);
      chk({tag, " result"}, result, exp);
      chk({tag, " busy in done"}, 64'(busy), 64'd0);
   endtask

   task automatic single_op(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [63:0] exp, input logic [63:0] hold, input bit inj);
      launch(ea, eb);
      wait_done(tag, exp, hold, inj);
      @(negedge clk);
      chk({tag, " done one cycle"}, 64'(done), 64'd0);
      chk({tag, " idle after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #3;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset result", result, 64'h0);
      @(negedge clk);
      reset = 1'b0;

      single_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 64'h0, 1'b0);
      single_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
                64'h0000_0000_0000_000F, 1'b0);
      single_op("0xn", 32'h0, 32'h1234_5678, 64'h0, 64'hFFFF_FFFE_0000_0001, 1'b0);
      single_op("msbx2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 64'h0, 1'b0);
      single_op("ign 7x6", 32'd7, 32'd6, 64'd42, 64'h0000_0001_0000_0000, 1'b1);

      // back-to-back: restart during the DONE cycle
      launch(32'd10, 32'd20);
      wait_done("b2b 10x20", 64'd200, 64'd42, 1'b0);
      start = 1'b1;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      chk("b2b no bubble busy", 64'(busy), 64'd1);
      chk("b2b no bubble done", 64'(done), 64'd0);
      wait_done("b2b 9x9", 64'd81, 64'd200, 1'b0);

      // asynchronous reset at EXEC cycle 15
      launch(32'hDEAD_BEEF, 32'h0BAD_F00D);
      repeat (14) @(negedge clk);
      chk("pre-reset busy", 64'(busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("async rst busy", 64'(busy), 64'd0);
      chk("async rst done", 64'(done), 64'd0);
      chk("async rst result", result, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      single_op("11x13", 32'd11, 32'd13, 64'd143, 64'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
